portal_msg_source: RTL and testbench
====================================

PORTAL_MSG_SOURCE -- requirements
Module: portal_msg_source

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: payload FIFO entries, power of 2, minimum 2.
REQ-002 Port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Port RST_N  in  1  reset, asynchronous and active-low.
REQ-004 Port hdr_valid  in  1  message header offered.
REQ-005 Port hdr_ready  out  1  header accepted this cycle.
REQ-006 Port hdr_method  in  16  method id of offered message.
REQ-007 Port hdr_words  in  16  payload word count (0..65535).
REQ-008 Port pay_valid  in  1  payload word offered.
REQ-009 Port pay_ready  out  1  payload FIFO can accept.
REQ-010 Port pay_data  in  32  payload word.
REQ-011 Port msgSource_src_rdy  out  1  beat valid toward host.
REQ-012 Port msgSource_dst_rdy_b  in  1  host can accept beat.
REQ-013 Port msgSource_beat  out  32  beat data.
REQ-014 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Beat transfer occurs on a rising CLK where msgSource_src_rdy and msgSource_dst_rdy_b are both 1; payload-FIFO push occurs when pay_valid and pay_ready are both 1.
REQ-016 Header beat format: bits[31:16] = method, bits[15:0] = payload word count.
REQ-017 FSM states: IDLE, HDR, PAY.
REQ-018 IDLE: hdr_ready = hdr_valid; on acceptance, latch method/words and enter HDR next cycle; msgSource_src_rdy = 0.
REQ-019 HDR: msgSource_src_rdy = 1, msgSource_beat = latched header; on transfer go to IDLE if words = 0, else go to PAY with remaining = words.
REQ-020 PAY: msgSource_src_rdy = FIFO not empty, msgSource_beat = FIFO head; each transfer pops the FIFO and decrements remaining; transfer with remaining = 1 returns to IDLE.
REQ-021 Header-accept to first header beat valid latency is exactly 1 cycle.
REQ-022 msgSource_beat and msgSource_src_rdy are held stable while src_rdy = 1 and dst_rdy_b = 0.
REQ-023 pay_ready = FIFO not full, independent of FSM state; payload may be pushed before its header.
REQ-024 Simultaneous push and pop are allowed when the FIFO is neither full nor empty; occupancy is unchanged.
REQ-025 No bypass: a word pushed into an empty FIFO is visible at msgSource_beat no earlier than the next cycle.
REQ-026 hdr_ready is 0 in HDR and PAY, so at most one message is in flight.
REQ-027 msgSource_beat in IDLE is 0.

Reset
REQ-028 With RST_N = 0: state becomes IDLE, the FIFO is emptied, remaining = 0, latched header = 0, and hdr_ready, msgSource_src_rdy, busy, and msgSource_beat are all 0, pay_ready = 1.
REQ-029 Reset asserted mid-message abandons the message without emitting further beats; after release, the block accepts a new header in the first cycle.

Configuration
REQ-030 Macro MSG_SOURCE_STATS_EN defined: add outputs msg_count[31:0] and beat_count[31:0], both reset to 0.
REQ-031 msg_count increments on each header-beat transfer; beat_count increments on every beat transfer; both wrap modulo 2^32.
REQ-032 Macro undefined: the stats ports and counters are absent, and the remaining behaviour is identical.

Structure
REQ-033 Package msg_source_pkg holds: the FSM state enum; HDR_METHOD_MSB/LSB and HDR_WORDS_MSB/LSB constants; the beat width constant (32).
REQ-034 Sub-module msg_fifo (synchronous FIFO, registered head, full/empty flags) implements the payload buffer.

Verification
REQ-035 Scenario: header (method 0x0005, 2 words) plus payload 0xA, 0xB, with dst_rdy_b held at 1 -> beats 0x00050002, 0xA, 0xB on three consecutive cycles, and busy is low after the third beat.
REQ-036 Scenario: header (0x0007, 0) -> a single beat 0x00070000, then IDLE; with MSG_SOURCE_STATS_EN defined, msg_count = 1 and beat_count = 1.
REQ-037 Scenario: dst_rdy_b = 0 for 5 cycles during the header beat -> beat stays 0x00050002 and src_rdy stays 1 throughout, then transfers once.
REQ-038 Scenario: push 16 words with no header (FIFO_DEPTH = 16) -> pay_ready goes 0 after the 16th push; a header with 16 words then drains all 16 in order.
REQ-039 Scenario: RST_N pulsed low after the 1st of 3 payload beats -> src_rdy drops 0 asynchronously, and the FIFO is empty; a subsequent header (0x0001, 1) plus word 0xC gives beats 0x00010001, 0xC.

Source files
------------

// File: rtl/msg_source_pkg.sv
// Shared types and constants for the portal message source.
package msg_source_pkg;

    localparam int unsigned BEAT_W          = 32;
    localparam int unsigned HDR_METHOD_MSB  = 31;
    localparam int unsigned HDR_METHOD_LSB  = 16;
    localparam int unsigned HDR_WORDS_MSB   = 15;
    localparam int unsigned HDR_WORDS_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous payload FIFO: register-array storage, occupancy counter,
// full/empty flags. A pushed word becomes visible at head one cycle later.
module msg_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    // Storage write; contents need no reset because the flags gate all use.
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/portal_msg_source.sv
// Portal message source: accepts a header and buffered payload words and
// emits a header beat followed by the payload beats toward the host.
// Optional statistics counters are enabled by defining MSG_SOURCE_STATS_EN.
module portal_msg_source
    import msg_source_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [15:0]       hdr_method,
    input  logic [15:0]       hdr_words,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic [31:0]       pay_data,
    output logic              msgSource_src_rdy,
    input  logic              msgSource_dst_rdy_b,
    output logic [BEAT_W-1:0] msgSource_beat,
`ifdef MSG_SOURCE_STATS_EN
    output logic [31:0]       msg_count,
    output logic [31:0]       beat_count,
`endif
    output logic              busy
);

    state_t             state;
    state_t             nextState;
    logic [BEAT_W-1:0]  hdrReg;
    logic [15:0]        remaining;
    logic [BEAT_W-1:0]  fifoHead;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPop;
    logic               xfer;

    msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) payFifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (pay_valid),
        .pushData (pay_data),
        .pop      (fifoPop),
        .head     (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign pay_ready = !fifoFull;
    assign busy      = (state != IDLE);
    assign xfer      = msgSource_src_rdy && msgSource_dst_rdy_b;

    // Next-state decode and handshake/beat outputs.
    always_comb begin
        nextState         = state;
        hdr_ready         = 1'b0;
        msgSource_src_rdy = 1'b0;
        msgSource_beat    = '0;
        fifoPop           = 1'b0;
        case (state)
            IDLE: begin
                hdr_ready = hdr_valid;
                if (hdr_valid) nextState = HDR;
            end
            HDR: begin
                msgSource_src_rdy = 1'b1;
                msgSource_beat    = hdrReg;
                if (msgSource_dst_rdy_b)
                    nextState = (hdrReg[HDR_WORDS_MSB:HDR_WORDS_LSB] == '0) ? IDLE : PAY;
            end
            PAY: begin
                msgSource_src_rdy = !fifoEmpty;
                msgSource_beat    = fifoHead;
                if (!fifoEmpty && msgSource_dst_rdy_b) begin
                    fifoPop = 1'b1;
                    if (remaining == 16'd1) nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register, latched header and payload countdown.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            hdrReg    <= '0;
            remaining <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && hdr_valid) begin
                hdrReg[HDR_METHOD_MSB:HDR_METHOD_LSB] <= hdr_method;
                hdrReg[HDR_WORDS_MSB:HDR_WORDS_LSB]   <= hdr_words;
            end
            if (state == HDR && msgSource_dst_rdy_b)
                remaining <= hdrReg[HDR_WORDS_MSB:HDR_WORDS_LSB];
            else if (state == PAY && xfer)
                remaining <= remaining - 16'd1;
        end
    end

`ifdef MSG_SOURCE_STATS_EN
    // Message and beat counters, wrapping modulo 2^32.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            msg_count  <= '0;
            beat_count <= '0;
        end else if (xfer) begin
            beat_count <= beat_count + 32'd1;
            if (state == HDR) msg_count <= msg_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_portal_msg_source.sv
// Self-checking bench for portal_msg_source: directed scenarios plus random
// traffic, all outputs compared every cycle against a message-level model.
module tb_portal_msg_source;

    localparam int unsigned DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [15:0] hdr_method = '0;
    logic [15:0] hdr_words = '0;
    logic        pay_valid = 1'b0;
    logic        pay_ready;
    logic [31:0] pay_data = '0;
    logic        src_rdy;
    logic        dst_rdy = 1'b0;
    logic [31:0] beat;
    logic        busy;
`ifdef MSG_SOURCE_STATS_EN
    logic [31:0] msg_count;
    logic [31:0] beat_count;
`endif

    portal_msg_source #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .hdr_valid           (hdr_valid),
        .hdr_ready           (hdr_ready),
        .hdr_method          (hdr_method),
        .hdr_words           (hdr_words),
        .pay_valid           (pay_valid),
        .pay_ready           (pay_ready),
        .pay_data            (pay_data),
        .msgSource_src_rdy   (src_rdy),
        .msgSource_dst_rdy_b (dst_rdy),
        .msgSource_beat      (beat),
`ifdef MSG_SOURCE_STATS_EN
        .msg_count           (msg_count),
        .beat_count          (beat_count),
`endif
        .busy                (busy)
    );

    always #5 CLK = ~CLK;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    // Reference model: payload words buffered, and the message in flight.
    logic [31:0] payQ[$];
    bit          msgActive = 0;
    bit          headerSent = 0;
    logic [15:0] mMethod = '0;
    logic [15:0] mWords = '0;
    int unsigned wordsLeft = 0;
    logic [31:0] mMsgs = '0;
    logic [31:0] mBeats = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic modelClear();
        payQ.delete();
        msgActive  = 0;
        headerSent = 0;
        wordsLeft  = 0;
        mMsgs      = '0;
        mBeats     = '0;
    endtask

    // One cycle: drive inputs, check outputs, advance the model, clock.
    task automatic step(input bit hv, input logic [15:0] m, input logic [15:0] w,
                        input bit pv, input logic [31:0] d, input bit dr);
        bit expSrc, pushIt, popIt, acceptIt;
        hdr_valid  = hv;
        hdr_method = m;
        hdr_words  = w;
        pay_valid  = pv;
        pay_data   = d;
        dst_rdy    = dr;
        #1;
        expSrc = msgActive && (!headerSent || payQ.size() > 0);
        chk("busy",      {31'b0, busy},      {31'b0, msgActive});
        chk("hdr_ready", {31'b0, hdr_ready}, {31'b0, !msgActive && hv});
        chk("pay_ready", {31'b0, pay_ready}, {31'b0, payQ.size() < DEPTH});
        chk("src_rdy",   {31'b0, src_rdy},   {31'b0, expSrc});
        if (!msgActive)       chk("beat_idle", beat, 32'h0);
        else if (!headerSent) chk("beat_hdr",  beat, {mMethod, mWords});
        else if (expSrc)      chk("beat_pay",  beat, payQ[0]);
`ifdef MSG_SOURCE_STATS_EN
        chk("msg_count",  msg_count,  mMsgs);
        chk("beat_count", beat_count, mBeats);
`endif
        pushIt   = pv && (payQ.size() < DEPTH);
        popIt    = expSrc && dr;
        acceptIt = !msgActive && hv;
        if (popIt) begin
            mBeats++;
            if (!headerSent) begin
                mMsgs++;
                headerSent = 1;
                wordsLeft  = mWords;
                if (mWords == 0) msgActive = 0;
            end else begin
                void'(payQ.pop_front());
                wordsLeft--;
                if (wordsLeft == 0) msgActive = 0;
            end
        end
        if (pushIt) payQ.push_back(d);
        if (acceptIt) begin
            msgActive  = 1;
            headerSent = 0;
            mMethod    = m;
            mWords     = w;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, '0, '0, 0, '0, 1);
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        #1;
        modelClear();
        chk("rst_src_rdy",   {31'b0, src_rdy},   32'h0);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        chk("rst_beat",      beat,               32'h0);
        chk("rst_pay_ready", {31'b0, pay_ready}, 32'h1);
        chk("rst_hdr_ready", {31'b0, hdr_ready}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        doReset();

        // Header plus two words, host always ready.
        step(0, '0, '0, 1, 32'hA, 1);
        step(1, 16'h0005, 16'd2, 1, 32'hB, 1);
        step(0, '0, '0, 0, '0, 1);
        step(0, '0, '0, 0, '0, 1);
        step(0, '0, '0, 0, '0, 1);
        chk("s35_busy_low", {31'b0, busy}, 32'h0);

        // Zero-length message and the stats counters.
        doReset();
        step(1, 16'h0007, 16'd0, 0, '0, 1);
        chk("s36_beat", beat, 32'h00070000);
        step(0, '0, '0, 0, '0, 1);
        chk("s36_idle", {31'b0, busy}, 32'h0);
`ifdef MSG_SOURCE_STATS_EN
        chk("s36_msgs",  msg_count,  32'd1);
        chk("s36_beats", beat_count, 32'd1);
`endif

        // Host stalls the header beat for five cycles.
        step(0, '0, '0, 1, 32'h11, 1);
        step(1, 16'h0005, 16'd2, 1, 32'h22, 0);
        for (int unsigned i = 0; i < 5; i++) step(0, '0, '0, 0, '0, 0);
        idle(4);

        // Fill the FIFO without a header, then drain it with one message.
        for (int unsigned i = 0; i < DEPTH; i++) step(0, '0, '0, 1, 32'h100 + i, 1);
        chk("s38_full", {31'b0, pay_ready}, 32'h0);
        step(1, 16'h0009, 16'(DEPTH), 1, 32'hDEAD, 1);
        idle(DEPTH + 3);

        // Reset in the middle of a payload.
        for (int unsigned i = 0; i < 3; i++) step(0, '0, '0, 1, 32'h200 + i, 1);
        step(1, 16'h0003, 16'd3, 0, '0, 1);
        step(0, '0, '0, 0, '0, 1);
        step(0, '0, '0, 0, '0, 1);
        #2;
        doReset();
        step(1, 16'h0001, 16'd1, 1, 32'hC, 1);
        step(0, '0, '0, 0, '0, 1);
        step(0, '0, '0, 0, '0, 1);
        idle(2);

        // Random traffic.
        for (int unsigned i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom_range(0, 5)),
                 $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
